// File: rtl/fixed_accumulator_pkg.sv
// fixed_accumulator_pkg: shared fixed-point widths, saturation limits and FSM state type.
package fixed_accumulator_pkg;
   localparam int FIX_W = 43;
   localparam int FIX_FRAC = 25;
   localparam logic [FIX_W-1:0] FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
   localparam logic [FIX_W-1:0] FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/sat_add_fixed.sv
// sat_add_fixed: combinational saturating 43-bit signed add.
// Ports: a, b = signed addends; sum = clamped result; ovf = addition overflowed and was clamped.
module sat_add_fixed
   import fixed_accumulator_pkg::*;
(
   input  logic [FIX_W-1:0] a,
   input  logic [FIX_W-1:0] b,
   output logic [FIX_W-1:0] sum,
   output logic             ovf
);
   logic [FIX_W-1:0] raw;
   logic pos, neg;
   assign raw = a + b;
   // Overflow only when both operands share a sign that the raw sum does not.
   assign pos = !a[FIX_W-1] && !b[FIX_W-1] && raw[FIX_W-1];
   assign neg = a[FIX_W-1] && b[FIX_W-1] && !raw[FIX_W-1];
   assign ovf = pos || neg;
   assign sum = pos ? FIX_MAX : neg ? FIX_MIN : raw;
endmodule

// File: rtl/fixed_accumulator.sv
// fixed_accumulator: windowed saturating accumulator of signed product terms onto a loaded bias.
// Ports: clk/reset (sync, active high); start + bias_in open a window; term_in/term_valid/term_last
// with term_ready handshake feed terms; acc_out/sat_flag/term_count hold the last window result,
// announced by a one-cycle out_valid; busy is high outside IDLE.
module fixed_accumulator
   import fixed_accumulator_pkg::*;
#(
   parameter int TERM_W = 36,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [FIX_W-1:0]  bias_in,
   input  logic [TERM_W-1:0] term_in,
   input  logic              term_valid,
   input  logic              term_last,
   output logic              term_ready,
   output logic [FIX_W-1:0]  acc_out,
   output logic              out_valid,
   output logic              sat_flag,
   output logic [CNT_W-1:0]  term_count,
   output logic              busy
);
   state_t state;
   logic [FIX_W-1:0] acc, term_ext, sum;
   logic [CNT_W-1:0] cnt;
   logic sat, ovf, take;
   assign term_ext = FIX_W'($signed(term_in));
   assign term_ready = state == ACCUM;
   assign busy = state != IDLE;
   assign take = term_valid && term_ready;
   sat_add_fixed u_add (.a(acc), .b(term_ext), .sum(sum), .ovf(ovf));
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         cnt        <= '0;
         sat        <= 1'b0;
         acc_out    <= '0;
         sat_flag   <= 1'b0;
         term_count <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= take && term_last;
         case (state)
            IDLE: if (start) begin
               state <= ACCUM;
               acc   <= bias_in;
               cnt   <= '0;
               sat   <= 1'b0;
            end
            ACCUM: if (term_valid) begin
               acc <= sum;
               cnt <= cnt + 1'b1;
               sat <= sat || ovf;
               // Result registers move only here so the downstream converter sees a stable value.
               if (term_last) begin
                  state      <= DONE;
                  acc_out    <= sum;
                  sat_flag   <= sat || ovf;
                  term_count <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fixed_accumulator.sv
// tb_fixed_accumulator: directed scoreboard bench for fixed_accumulator with a saturating reference model.
module tb_fixed_accumulator;
   localparam int TERM_W = 36;
   localparam int CNT_W = 16;
   localparam longint FMAX = (longint'(1) <<< 42) - 1;
   localparam longint FMIN = -(longint'(1) <<< 42);
   typedef struct {
      logic [42:0] acc;
      logic        sat;
      logic [15:0] cnt;
   } res_t;
   logic clk = 1'b0;
   logic reset, start, term_valid, term_last;
   logic [42:0] bias_in;
   logic [TERM_W-1:0] term_in;
   logic term_ready, out_valid, sat_flag, busy;
   logic [42:0] acc_out;
   logic [CNT_W-1:0] term_count;
   int n_checks = 0;
   int n_err = 0;
   res_t q[$];
   longint m_acc;
   int m_cnt;
   logic m_sat;
   logic [59:0] held;
   fixed_accumulator #(.TERM_W(TERM_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .bias_in(bias_in), .term_in(term_in),
      .term_valid(term_valid), .term_last(term_last), .term_ready(term_ready), .acc_out(acc_out),
      .out_valid(out_valid), .sat_flag(sat_flag), .term_count(term_count), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // Advance one clock; results may only change at an out_valid edge or under reset.
   task automatic tick();
      logic r;
      @(posedge clk);
      r = reset;
      #1;
      if (out_valid || r) held = {acc_out, sat_flag, term_count};
      else chk("hold", {4'b0, acc_out, sat_flag, term_count}, {4'b0, held});
   endtask
   task automatic do_start(input logic [42:0] bias);
      start = 1'b1;
      bias_in = bias;
      tick();
      start = 1'b0;
      bias_in = $urandom;
      m_acc = longint'($signed(bias));
      m_cnt = 0;
      m_sat = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ready", term_ready, 1);
   endtask
   task automatic send_term(input longint v, input bit last, input bit rnd);
      bit done = 0;
      bit vld;
      int guard = 0;
      longint s;
      res_t e, r;
      while (!done) begin
         vld = (rnd && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         term_valid = vld;
         term_in = vld ? TERM_W'(v) : TERM_W'($urandom);
         term_last = vld ? last : 1'($urandom_range(0, 1));
         chk("ready_accum", term_ready, 1);
         tick();
         guard++;
         if (vld) done = 1;
      end
      term_valid = 1'b0;
      term_last = 1'b0;
      s = m_acc + v;
      if (s > FMAX) begin s = FMAX; m_sat = 1'b1; end
      else if (s < FMIN) begin s = FMIN; m_sat = 1'b1; end
      m_acc = s;
      m_cnt++;
      if (last) begin
         e.acc = 43'(m_acc);
         e.sat = m_sat;
         e.cnt = 16'(m_cnt);
         q.push_back(e);
         chk("out_valid_latency", out_valid, 1);
         if (out_valid) begin
            r = q.pop_front();
            chk("acc_out", acc_out, r.acc);
            chk("sat_flag", sat_flag, r.sat);
            chk("term_count", term_count, r.cnt);
         end
      end
   endtask
   task automatic after_done();
      tick();
      chk("pulse_end", out_valid, 0);
      chk("idle_busy", busy, 0);
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      bias_in = '0;
      term_in = '0;
      term_valid = 1'b0;
      term_last = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_acc", acc_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", term_count, 0);
      chk("rst_sat", sat_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", term_ready, 0);
      // Terms offered while idle must be ignored.
      term_valid = 1'b1;
      term_last = 1'b1;
      term_in = TERM_W'(7);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_term_busy", busy, 0);
         chk("idle_term_valid", out_valid, 0);
         chk("idle_term_ready", term_ready, 0);
      end
      term_valid = 1'b0;
      term_last = 1'b0;
      // 1.0 + 1.0 + 0.5 - 0.5 = 2.0
      do_start(43'h2000000);
      send_term(64'sh2000000, 0, 0);
      send_term(64'sh1000000, 0, 0);
      send_term(-64'sh1000000, 1, 0);
      chk("r19_acc", acc_out, 43'h4000000);
      chk("r19_cnt", term_count, 3);
      after_done();
      // Positive saturation.
      do_start(43'h3FFFFFFFFF0);
      send_term(64'sh100, 1, 0);
      chk("r20a_acc", acc_out, 43'h3FFFFFFFFFF);
      chk("r20a_sat", sat_flag, 1);
      after_done();
      // Saturate, then pull back in range; sticky flag remains.
      do_start(43'h3FFFFFFFFF0);
      send_term(64'sh100, 0, 0);
      send_term(-64'sh200, 1, 0);
      chk("r20b_acc", acc_out, 43'h3FFFFFFFDFF);
      chk("r20b_sat", sat_flag, 1);
      after_done();
      // Negative saturation.
      do_start(43'h40000000010);
      send_term(-64'sh100, 1, 0);
      chk("r21_acc", acc_out, 43'h40000000000);
      chk("r21_sat", sat_flag, 1);
      after_done();
      // Randomly gapped term_valid; only handshaked terms count.
      do_start(43'(longint'($urandom_range(0, 4000)) - 2000));
      for (int i = 0; i < 8; i++) send_term(longint'($urandom_range(0, 200000)) - 100000, i == 7, 1);
      after_done();
      // start held through ACCUM and DONE: no reload, no queueing, restart after one IDLE cycle.
      do_start(43'h2000000);
      send_term(64'sh100, 0, 0);
      start = 1'b1;
      bias_in = 43'h10;
      send_term(64'sh200, 1, 0);
      chk("held_acc", acc_out, 43'h2000300);
      tick();
      chk("held_done_exit_busy", busy, 0);
      chk("held_done_exit_valid", out_valid, 0);
      tick();
      chk("held_restart_busy", busy, 1);
      chk("held_restart_ready", term_ready, 1);
      start = 1'b0;
      m_acc = 64'sh10;
      m_cnt = 0;
      m_sat = 1'b0;
      send_term(5, 1, 0);
      chk("held_new_acc", acc_out, 43'h15);
      after_done();
      // Reset mid-window discards the partial sum.
      do_start(43'h0);
      send_term(1, 0, 0);
      send_term(2, 0, 0);
      reset = 1'b1;
      term_valid = 1'b1;
      term_last = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_acc", acc_out, 0);
      chk("abort_cnt", term_count, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("abort_idle_valid", out_valid, 0);
         chk("abort_idle_busy", busy, 0);
      end
      term_valid = 1'b0;
      term_last = 1'b0;
      do_start(43'h0);
      send_term(5, 1, 0);
      chk("fresh_acc", acc_out, 43'h5);
      chk("fresh_cnt", term_count, 1);
      after_done();
      for (int i = 0; i < 3; i++) tick();
      chk("sb_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
